fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the instruction decoder/control block. Holds the PC, requests 16-bit instructions from instruction memory over a ready handshake, and presents one instruction at a time to the decoder. It advances to PC+2, a redirect target, or a permanent halt, and inserts a NOP encoding whenever no valid instruction is available.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_pc_reg.sv | 33 +++
 rtl/fetch_unit.sv | 88 ++++++++
 tb/tb_fetch_unit.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ---- fetch_pkg : shared types and constants for the instruction fetch stage ----
// ---- rev 1.0                                                                 ----
package fetch_pkg;

  localparam int INSTR_W = 16;
  localparam int PC_W    = 16;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0800;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_pc_reg.sv
`default_nettype none
// ---- fetch_pc_reg : program counter with reset, target load and +2 increment ----
// ---- rev 1.0                                                                 ----
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            incr,
  input  logic [PC_W-1:0] load_pc,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_q;

  // Instructions are halfword aligned, so bit 0 is never allowed to be set.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= {RESET_PC[PC_W-1:1], 1'b0};
    end else if (load) begin
      pc_q <= {load_pc[PC_W-1:1], 1'b0};
    end else if (incr) begin
      pc_q <= pc_q + 16'd2;
    end
  end

  assign pc = pc_q;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ---- fetch_unit : PC, instruction memory handshake and single-entry decoder feed ----
// ---- rev 1.0                                                                     ----
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ready,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [PC_W-1:0]    pc,
  output logic [PC_W-1:0]    pc_plus2,
  input  logic               stall,
  input  logic               halt,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               halted,
  output logic [15:0]        retired
);

  state_t             state;
  logic [INSTR_W-1:0] instr_q;
  logic [15:0]        retired_q;
  logic [PC_W-1:0]    pc_w;
  logic               accept;
  logic               pc_load;
  logic               pc_incr;

  assign accept  = (state == HOLD) && !stall;
  assign pc_load = accept && !halt && redirect;
  assign pc_incr = accept && !halt && !redirect;

  fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk     (clk),
    .rst     (rst),
    .load    (pc_load),
    .incr    (pc_incr),
    .load_pc (redirect_pc),
    .pc      (pc_w)
  );

  // instr_q reverts to NOP whenever HOLD is left, so instr is a direct register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      instr_q   <= NOP_INSTR;
      retired_q <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ready) begin
            instr_q <= imem_rdata;
            state   <= HOLD;
          end
        end
        HOLD: begin
          if (!stall) begin
            retired_q <= retired_q + 16'd1;
            instr_q   <= NOP_INSTR;
            state     <= halt ? HALTED : FETCH;
          end
        end
        HALTED:  state <= HALTED;
        default: state <= FETCH;
      endcase
    end
  end

  // A late request must never be seen by memory while reset is held.
  assign imem_req    = (state == FETCH) && !rst;
  assign imem_addr   = pc_w;
  assign instr       = instr_q;
  assign instr_valid = (state == HOLD);
  assign halted      = (state == HALTED);
  assign pc          = pc_w;
  assign pc_plus2    = pc_w + 16'd2;
  assign retired     = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ---- tb_fetch_unit : randomized scoreboard bench for fetch_unit ----
// ---- rev 1.0                                                    ----
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [15:0] RST_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata = '0;
  logic        imem_ready = 1'b0;
  logic [15:0] instr;
  logic        instr_valid;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic        stall = 1'b0;
  logic        halt = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        halted;
  logic [15:0] retired;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ready  (imem_ready),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus2    (pc_plus2),
    .stall       (stall),
    .halt        (halt),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halted      (halted),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] ret;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: the architectural program counter and retire count.
  logic [15:0] m_pc = RST_PC;
  logic [15:0] m_ret = '0;
  bit          m_halted = 1'b0;
  bit          directed = 1'b0;
  bit          req_active = 1'b0;
  bit          in_hold = 1'b0;
  int          wait_rem = 0;
  int          stall_rem = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] pick_target();
    case ($urandom_range(0, 5))
      0:       return 16'h0101;
      1:       return 16'hFFFE;
      2:       return 16'hFFFF;
      3:       return 16'h0010;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic do_reset(input int n, input bit ready_hi);
    rst        = 1'b1;
    imem_ready = ready_hi;
    imem_rdata = 16'($urandom);
    stall      = 1'($urandom);
    halt       = 1'($urandom);
    redirect   = 1'($urandom);
    repeat (n) begin
      @(posedge clk); #1;
      chk("rst_pc", pc, RST_PC);
      chk("rst_instr", instr, NOP_INSTR);
      chk("rst_valid", 16'(instr_valid), 16'd0);
      chk("rst_req", 16'(imem_req), 16'd0);
      chk("rst_retired", retired, 16'd0);
      chk("rst_halted", 16'(halted), 16'd0);
    end
    sb.delete();
    m_pc       = RST_PC;
    m_ret      = '0;
    m_halted   = 1'b0;
    req_active = 1'b0;
    in_hold    = 1'b0;
    rst        = 1'b0;
    imem_ready = 1'b0;
    stall      = 1'b0;
    halt       = 1'b0;
    redirect   = 1'b0;
    #1;
  endtask

  // Called shortly after a rising edge; sets inputs for the coming edge.
  task automatic drive_cycle();
    int r;
    imem_ready  = 1'b0;
    imem_rdata  = 16'($urandom);
    stall       = 1'($urandom);
    halt        = 1'($urandom);
    redirect    = 1'($urandom);
    redirect_pc = 16'($urandom);
    if (imem_req) begin
      chk("imem_addr", imem_addr, m_pc);
      chk("fetch_instr_nop", instr, NOP_INSTR);
      chk("fetch_valid", 16'(instr_valid), 16'd0);
      if (!req_active) begin
        req_active = 1'b1;
        wait_rem   = directed ? 0 : $urandom_range(0, 3);
      end
      if (wait_rem == 0) begin
        imem_ready = 1'b1;
        if (directed) imem_rdata = 16'h4000;
        chk("sb_depth", 16'(sb.size()), 16'd0);
        sb.push_back('{pc: m_pc, instr: imem_rdata, ret: m_ret});
        req_active = 1'b0;
      end else begin
        wait_rem--;
      end
    end else if (instr_valid) begin
      imem_ready = 1'($urandom);
      if (!in_hold) begin
        in_hold   = 1'b1;
        stall_rem = (directed || $urandom_range(0, 3) != 0) ? 0 : $urandom_range(1, 6);
      end
      if (stall_rem > 0) begin
        stall = 1'b1;
        stall_rem--;
      end else begin
        stall    = 1'b0;
        halt     = 1'b0;
        redirect = 1'b0;
        in_hold  = 1'b0;
        m_ret    = m_ret + 16'd1;
        r        = $urandom_range(0, 99);
        if (!directed && r < 3) begin
          halt     = 1'b1;
          redirect = 1'($urandom);
          m_halted = 1'b1;
        end else if (!directed && r < 30) begin
          redirect    = 1'b1;
          redirect_pc = pick_target();
          m_pc        = redirect_pc & 16'hFFFE;
        end else begin
          m_pc = m_pc + 16'd2;
        end
      end
    end else begin
      imem_ready = 1'($urandom);
    end
  endtask

  // Monitor: pops one expectation per presented instruction, checks it while held.
  exp_t cur;
  bit   have = 1'b0;
  bit   prev_valid = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      have       = 1'b0;
    end else begin
      if (instr_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          have = 1'b0;
          $display("FAIL unexpected_instr: got pc %h instr %h with empty scoreboard", pc, instr);
        end else begin
          cur  = sb.pop_front();
          have = 1'b1;
        end
      end
      if (instr_valid && have) begin
        chk("instr", instr, cur.instr);
        chk("pc", pc, cur.pc);
        chk("pc_plus2", pc_plus2, cur.pc + 16'd2);
        chk("retired", retired, cur.ret);
      end
      prev_valid = instr_valid;
    end
  end

  initial begin
    do_reset(2, 1'b1);

    // Zero-wait memory, no stalls: three instructions retire in six cycles.
    directed = 1'b1;
    repeat (6) begin
      drive_cycle();
      @(posedge clk); #1;
    end
    chk("zero_wait_retired", retired, 16'd3);
    chk("zero_wait_pc", pc, 16'd6);
    directed = 1'b0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (m_halted) begin
        for (int k = 0; k < 20; k++) begin
          chk("halted", 16'(halted), 16'd1);
          chk("halted_req", 16'(imem_req), 16'd0);
          chk("halted_valid", 16'(instr_valid), 16'd0);
          chk("halted_pc", pc, m_pc);
          chk("halted_retired", retired, m_ret);
          drive_cycle();
          @(posedge clk); #1;
        end
        do_reset($urandom_range(1, 2), 1'($urandom));
      end else if (imem_req && $urandom_range(0, 99) == 0) begin
        do_reset(1, 1'b1);
      end else begin
        drive_cycle();
        @(posedge clk); #1;
      end
    end

    // Reset landing on a cycle where memory completes the request.
    for (int k = 0; k < 20 && !imem_req; k++) begin
      drive_cycle();
      @(posedge clk); #1;
    end
    chk("final_req_seen", 16'(imem_req), 16'd1);
    do_reset(1, 1'b1);
    chk("post_rst_addr", imem_addr, RST_PC);
    chk("post_rst_req", 16'(imem_req), 16'd1);
    repeat (4) begin
      drive_cycle();
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
